// File: rtl/vwrite_pkg.sv
// Shared widths and port-A FSM states for the vwrite stream-to-memory unit.
// Optional bit-reversed port-B addressing is enabled with VWRITE_REVERSE_EN.
package vwrite_pkg;
  localparam int IO_ADDR_W  = 32;
  localparam int MEM_ADDR_W = 10;
  localparam int IO_SIZE_W  = 11;
  localparam int PERIOD_W   = 10;

  typedef enum logic [1:0] {
    VW_IDLE,
    VW_RD,
    VW_WR
  } vwState_t;
endpackage

// File: rtl/iob_2p_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data appears one cycle after r_en and holds until the next read.
module iob_2p_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] data_out
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= data_in;
    if (r_en) data_out <= mem[r_addr];
  end
endmodule

// File: rtl/vwrite_ext_wr.sv
// Port-A drain engine: reads one RAM word, then holds a single-word
// databus write until ready; at most one word every two cycles.
module vwrite_ext_wr
  import vwrite_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [IO_SIZE_W-1:0] size,
  input  logic [IO_ADDR_W-1:0] extAddr,
  input  logic                 ready,
  input  logic [DATA_W-1:0]    rdData,
  output logic                 done,
  output logic                 rEn,
  output logic [IO_SIZE_W-1:0] cnt,
  output logic                 valid,
  output logic [IO_ADDR_W-1:0] addr,
  output logic [DATA_W-1:0]    wdata,
  output logic [DATA_W/8-1:0]  wstrb
);
  localparam int BYTE_SH = $clog2(DATA_W/8);

  vwState_t state;

  assign done  = (state == VW_IDLE);
  assign rEn   = (state == VW_RD);
  assign wdata = valid ? rdData : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= VW_IDLE;
      cnt   <= '0;
      valid <= 1'b0;
      addr  <= '0;
      wstrb <= '0;
    end else begin
      unique case (state)
        VW_IDLE: begin
          if (run && size != '0) begin
            state <= VW_RD;
            cnt   <= '0;
          end
        end
        VW_RD: begin
          state <= VW_WR;
          valid <= 1'b1;
          wstrb <= '1;
          addr  <= extAddr + (IO_ADDR_W'(cnt) << BYTE_SH);
        end
        VW_WR: begin
          if (ready) begin
            cnt   <= cnt + 1'b1;
            valid <= 1'b0;
            wstrb <= '0;
            addr  <= '0;
            state <= (cnt == size - 1'b1) ? VW_IDLE : VW_RD;
          end
        end
        default: state <= VW_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/xaddrgen.sv
// Nested-loop address generator: iterations x period, duty-gated enable.
// Runs after an optional start delay; done is high whenever idle.
module xaddrgen
  import vwrite_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [MEM_ADDR_W-1:0] iterations,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [PERIOD_W-1:0]   duty,
  input  logic [MEM_ADDR_W-1:0] start,
  input  logic [MEM_ADDR_W-1:0] shift,
  input  logic [MEM_ADDR_W-1:0] incr,
  input  logic [9:0]            delay,
  output logic [MEM_ADDR_W-1:0] addr,
  output logic                  memEn,
  output logic                  done
);
  logic                  running;
  logic [9:0]            dlyCnt;
  logic [MEM_ADDR_W-1:0] iterCnt;
  logic [PERIOD_W-1:0]   perCnt;
  logic                  active;

  assign active = running && (dlyCnt == '0);
  assign memEn  = active && (perCnt < duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      done    <= 1'b1;
      dlyCnt  <= '0;
      iterCnt <= '0;
      perCnt  <= '0;
      addr    <= '0;
    end else if (run) begin
      addr    <= start;
      iterCnt <= '0;
      perCnt  <= '0;
      dlyCnt  <= delay;
      running <= (iterations != '0) && (period != '0);
      done    <= (iterations == '0) || (period == '0);
    end else if (running) begin
      if (dlyCnt != '0) begin
        dlyCnt <= dlyCnt - 1'b1;
      end else if (perCnt == period - 1'b1) begin
        perCnt  <= '0;
        addr    <= addr + (memEn ? incr : '0) + shift;
        iterCnt <= iterCnt + 1'b1;
        if (iterCnt == iterations - 1'b1) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end else begin
        perCnt <= perCnt + 1'b1;
        if (memEn) addr <= addr + incr;
      end
    end
  end
endmodule

// File: rtl/vwrite.sv
// Versat stream-to-memory write unit with ping-pong RAM halves.
// Define VWRITE_REVERSE_EN to enable bit-reversed port-B addressing.
module vwrite
  import vwrite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  done,
  input  logic                  databus_ready,
  output logic                  databus_valid,
  output logic [IO_ADDR_W-1:0]  databus_addr,
  input  logic [DATA_W-1:0]     databus_rdata,
  output logic [DATA_W-1:0]     databus_wdata,
  output logic [DATA_W/8-1:0]   databus_wstrb,
  input  logic [DATA_W-1:0]     in0,
  input  logic [IO_ADDR_W-1:0]  ext_addr,
  input  logic [MEM_ADDR_W-1:0] int_addr,
  input  logic [IO_SIZE_W-1:0]  size,
  input  logic                  pingPong,
  input  logic [MEM_ADDR_W-1:0] iterB,
  input  logic [PERIOD_W-1:0]   perB,
  input  logic [PERIOD_W-1:0]   dutyB,
  input  logic [MEM_ADDR_W-1:0] startB,
  input  logic [MEM_ADDR_W-1:0] shiftB,
  input  logic [MEM_ADDR_W-1:0] incrB,
  input  logic [31:0]           delay0,
  input  logic                  reverseB
);
  logic                  doneA, doneB, runAcc, pps;
  logic                  memEn, rEn;
  logic [MEM_ADDR_W-1:0] genAddr;
  logic [IO_SIZE_W-1:0]  cnt;
  logic [DATA_W-1:0]     ramData;
  logic [ADDR_W-1:0]     rawB, selB, addrB, rawA, addrA;

  assign done   = doneA & doneB;
  assign runAcc = run & done;

  // pps names the half port B fills this run; port A drains the other
  always_ff @(posedge clk) begin
    if (rst) pps <= 1'b0;
    else if (runAcc) pps <= pingPong ? ~pps : 1'b0;
  end

  xaddrgen addrGen (
    .clk       (clk),
    .rst       (rst),
    .run       (runAcc),
    .iterations(iterB),
    .period    (perB),
    .duty      (dutyB),
    .start     (startB),
    .shift     (shiftB),
    .incr      (incrB),
    .delay     (delay0[9:0]),
    .addr      (genAddr),
    .memEn     (memEn),
    .done      (doneB)
  );

  assign rawB = genAddr[ADDR_W-1:0];

`ifdef VWRITE_REVERSE_EN
  logic [ADDR_W-1:0] revB;
  always_comb begin
    revB = '0;
    for (int i = 0; i < ADDR_W; i++) revB[i] = rawB[ADDR_W-1-i];
  end
  assign selB = reverseB ? revB : rawB;
  logic unusedRev;
  assign unusedRev = 1'b0;
`else
  assign selB = rawB;
  logic unusedRev;
  assign unusedRev = reverseB;
`endif

  assign addrB = pingPong ? {pps, selB[ADDR_W-2:0]} : selB;
  assign rawA  = int_addr[ADDR_W-1:0] + cnt[ADDR_W-1:0];
  assign addrA = pingPong ? {~pps, rawA[ADDR_W-2:0]} : rawA;

  vwrite_ext_wr #(.DATA_W(DATA_W)) extWr (
    .clk    (clk),
    .rst    (rst),
    .run    (runAcc),
    .size   (size),
    .extAddr(ext_addr),
    .ready  (databus_ready),
    .rdData (ramData),
    .done   (doneA),
    .rEn    (rEn),
    .cnt    (cnt),
    .valid  (databus_valid),
    .addr   (databus_addr),
    .wdata  (databus_wdata),
    .wstrb  (databus_wstrb)
  );

  iob_2p_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram (
    .clk     (clk),
    .w_en    (memEn),
    .w_addr  (addrB),
    .data_in (in0),
    .r_en    (rEn),
    .r_addr  (addrA),
    .data_out(ramData)
  );

  logic unused;
  assign unused = ^{delay0[31:10], databus_rdata,
                    cnt[IO_SIZE_W-1:ADDR_W], unusedRev};
endmodule

// File: tb/tb_vwrite.sv
// Directed bench for vwrite: fill, drain, backpressure, ping-pong, reset.
// Bit-reverse expectation follows VWRITE_REVERSE_EN.
module tb_vwrite;
  import vwrite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic ready = 1'b0;
  logic pingPong = 1'b0;
  logic reverseB = 1'b0;
  logic done, valid;
  logic [IO_ADDR_W-1:0]  busAddr;
  logic [31:0]           rdata = '0;
  logic [31:0]           wdata;
  logic [31:0]           in0 = '0;
  logic [3:0]            wstrb;
  logic [IO_ADDR_W-1:0]  extAddr = '0;
  logic [MEM_ADDR_W-1:0] intAddr = '0;
  logic [MEM_ADDR_W-1:0] iterB = '0, startB = '0, shiftB = '0, incrB = '0;
  logic [PERIOD_W-1:0]   perB = '0, dutyB = '0;
  logic [IO_SIZE_W-1:0]  size = '0;
  logic [31:0]           delay0 = '0;

  int errors = 0;
  int checks = 0;
  int wrCount = 0;
  int base, cyc;
  logic [31:0] logA [64];
  logic [31:0] logD [64];

  always #5 clk = ~clk;

  vwrite dut (
    .clk(clk), .rst(rst), .run(run), .done(done),
    .databus_ready(ready), .databus_valid(valid),
    .databus_addr(busAddr), .databus_rdata(rdata),
    .databus_wdata(wdata), .databus_wstrb(wstrb),
    .in0(in0), .ext_addr(extAddr), .int_addr(intAddr),
    .size(size), .pingPong(pingPong),
    .iterB(iterB), .perB(perB), .dutyB(dutyB),
    .startB(startB), .shiftB(shiftB), .incrB(incrB),
    .delay0(delay0), .reverseB(reverseB)
  );

  always @(posedge clk) begin
    if (!rst && valid && ready) begin
      if (wrCount < 64) begin
        logA[wrCount] <= busAddr;
        logD[wrCount] <= wdata;
      end
      wrCount <= wrCount + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runFill(input logic [31:0] first, output int c);
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0; in0 = first;
    c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
      in0 = first + c;
    end
    chk("done_timeout", 64'(c < 200), 64'd1);
  endtask

  task automatic chkLog(input string tag, input int b, input int n,
                        input logic [31:0] a0, input logic [31:0] d0);
    chk({tag, "_count"}, 64'(wrCount - b), 64'(n));
    for (int k = 0; k < n; k++) begin
      chk({tag, "_addr"}, 64'(logA[b+k]), 64'(a0 + 32'(4*k)));
      chk({tag, "_data"}, 64'(logD[b+k]), 64'(d0 + 32'(k)));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_done", 64'(done), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'd0);
    chk("rst_addr", 64'(busAddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    rst = 1'b0;

    // 1: fill RAM[0..3], then drain at full rate
    iterB = 4; perB = 1; dutyB = 1; incrB = 1; startB = 0;
    runFill(32'hA0, cyc);
    chk("fill1_cyc", 64'(cyc), 64'd4);
    iterB = 0; size = 4; extAddr = 32'h100; ready = 1'b1;
    base = wrCount;
    runFill(32'h0, cyc);
    chk("drain1_cyc", 64'(cyc), 64'd8);
    chkLog("drain1", base, 4, 32'h100, 32'hA0);

    // 2: backpressure, ready low three cycles per word
    ready = 1'b0; extAddr = 32'h200; base = wrCount;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("bp_valid_up", 64'(valid), 64'd1);
      repeat (3) begin
        chk("bp_hold_valid", 64'(valid), 64'd1);
        chk("bp_hold_addr", 64'(busAddr), 64'(32'h200 + 32'(4*k)));
        chk("bp_hold_data", 64'(wdata), 64'(32'hA0 + 32'(k)));
        chk("bp_hold_wstrb", 64'(wstrb), 64'hF);
        @(negedge clk);
      end
      if (k == 3) chk("bp_done_low", 64'(done), 64'd0);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
    chk("bp_done_up", 64'(done), 64'd1);
    chkLog("bp", base, 4, 32'h200, 32'hA0);

    // 3: size zero, then run while busy
    size = 0; base = wrCount;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (4) begin
      chk("sz0_done", 64'(done), 64'd1);
      chk("sz0_valid", 64'(valid), 64'd0);
      @(negedge clk);
    end
    chk("sz0_count", 64'(wrCount - base), 64'd0);
    size = 4; extAddr = 32'h300; ready = 1'b1; base = wrCount;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    chk("busy_done", 64'(done), 64'd1);
    chkLog("busy", base, 4, 32'h300, 32'hA0);

    // 4: ping-pong halves
    pingPong = 1'b1; size = 0; iterB = 4;
    runFill(32'hB0, cyc);
    chk("pp_fill_cyc", 64'(cyc), 64'd4);
    size = 4; extAddr = 32'h400; base = wrCount;
    runFill(32'hC0, cyc);
    chk("pp_run2_cyc", 64'(cyc), 64'd8);
    chkLog("pp_run2", base, 4, 32'h400, 32'hB0);
    iterB = 0; extAddr = 32'h500; base = wrCount;
    runFill(32'h0, cyc);
    chkLog("pp_run3", base, 4, 32'h500, 32'hC0);

    // 5: reset during a stalled write
    pingPong = 1'b0; ready = 1'b0; extAddr = 32'h600;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    cyc = 0;
    while (!valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_valid_up", 64'(valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_valid", 64'(valid), 64'd0);
    chk("mid_done", 64'(done), 64'd1);
    chk("mid_wstrb", 64'(wstrb), 64'd0);
    chk("mid_addr", 64'(busAddr), 64'd0);
    ready = 1'b1; size = 2; base = wrCount;
    runFill(32'h0, cyc);
    chk("mid_fresh_cyc", 64'(cyc), 64'd4);
    chkLog("mid_fresh", base, 2, 32'h600, 32'hC0);

    // 6: bit-reversed port-B address
    startB = 1; iterB = 1; reverseB = 1'b1; size = 0;
    runFill(32'hD1, cyc);
    iterB = 0; size = 1; extAddr = 32'h700; base = wrCount;
`ifdef VWRITE_REVERSE_EN
    intAddr = 10'd512;
`else
    intAddr = 10'd1;
`endif
    runFill(32'h0, cyc);
    chk("rev_cyc", 64'(cyc), 64'd2);
    chkLog("rev", base, 1, 32'h700, 32'hD1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
